vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing and test-pattern generator, the successor to the fixed 640x480 controller.
- Sync, back-porch, active and front-porch lengths and sync polarities are parameters; pixel rate is derived from `clk` by an integer clock-enable, not a divided clock.
- Outputs registered hsync/vsync/de, pixel coordinates, frame/line strobes and RGB from one of four selectable patterns.
- Sits between the board clock and the DAC/HDMI pins. Later, a frame-buffer reader consumes `x`/`y`/`de` instead of the pattern path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- HS_POL, 1, active level of hsync
- VS_POL, 1, active level of vsync
- COLOR_W, 8, bits per colour channel
- BAR_W, 80, colour-bar width in pixels
- CHK_LOG2, 5, checkerboard square = 2^CHK_LOG2 pixels

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 gradient
- solid_rgb  in  3*COLOR_W  {R,G,B} colour used in mode 0
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- de  out  1  display enable (active video)
- x  out  clog2(H_ACTIVE)  active pixel column, 0 when de=0
- y  out  clog2(V_ACTIVE)  active line, 0 when de=0
- line_start  out  1  one-clk pulse, first active pixel of each line
- frame_start  out  1  one-clk pulse, first active pixel of frame (x=0,y=0)
- R, G, B  out  COLOR_W each  pixel colour, 0 when de=0

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Region order in both axes: sync, back porch, active, front porch. Counter value 0 is the first sync pixel/line.
- Pixel enable:
  - Counter `div` runs 0..CLK_DIV-1; `pix_en` = (div == CLK_DIV-1).
  - CLK_DIV=1 gives `pix_en` constantly 1.
- Counters:
  - On `pix_en`: hcnt wraps H_TOTAL-1 -> 0. When hcnt wraps, vcnt increments and wraps V_TOTAL-1 -> 0.
  - Counter widths are clog2(total).
- Active region: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Output stage:
  - All outputs are registered and load only on `pix_en` edges, from the decode of the pre-increment hcnt/vcnt.
  - Latency: outputs lag counters by exactly one pixel tick; hsync, vsync, de and RGB stay mutually aligned.
  - `line_start`/`frame_start` are high for the single clk cycle after the loading edge, then 0. With CLK_DIV=1 they are 1-cycle pulses.
- Sync: active level while the counter is in the sync region, inverse otherwise.
- Mode latching: `mode` and `solid_rgb` are sampled into shadow registers when the decode hits hcnt=0, vcnt=0. Pattern changes only at frame boundaries; no mid-frame tearing.
- Patterns (RGB = 0 whenever de=0):
  - Mode 0: RGB = shadow `solid_rgb`.
  - Mode 1: bar index k is 0 at x=0 and increments every BAR_W pixels, wrapping mod 8. Colour = 7-k with R=bit2, G=bit1, B=bit0, each mapped to all-ones or 0. Bar 0 is white, bar 7 is black. Implement with a counter, no divider.
  - Mode 2: white if x[CHK_LOG2]^y[CHK_LOG2] else black.
  - Mode 3: R = x[COLOR_W-1:0], G = y[COLOR_W-1:0], B = frame counter. The frame counter is COLOR_W bits, increments at each frame wrap and wraps naturally.
- Reset (async, any time):
  - div, hcnt, vcnt, frame counter, bar counter: 0.
  - Shadow mode: 0; shadow colour: 0.
  - Outputs: hsync = !HS_POL, vsync = !VS_POL, de = 0, x = y = 0, RGB = 0, both strobes = 0.
  - After release, the first `pix_en` edge loads sync-active levels for hcnt=0, vcnt=0.
- Simultaneous last pixel of the last line: hcnt and vcnt both wrap on the same edge, and the frame counter increments on that edge.

Test Plan:
- Defaults, CLK_DIV=2, run 2 frames:
  - hsync high 192 clk every 1600 clk; vsync high 3200 clk every 840000 clk.
  - de high 1280 clk per line on 480 lines/frame.
- Reset asserted mid-line (hcnt≈300), held 5 clk, released:
  - Outputs go to reset values asynchronously (same cycle).
  - First hsync rising edge comes 2 clk after release; line timing restarts from 0.
- mode=1, defaults:
  - Line 0: x=0..79 RGB=FFFFFF, x=80..159 FFFF00, ..., x=560..639 000000.
  - de=0 forces RGB=0.
- mode switched 0->2 mid-frame:
  - Solid colour persists to the end of frame.
  - Checkerboard starts at the next frame_start: (x=32,y=0) white, (x=32,y=32) black.
- CLK_DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=0:
  - Line period 14 clk, frame 98 clk, hsync low 2 clk.
  - frame_start exactly one 1-clk pulse per 98 clk, coinciding with x=0,y=0,de=1.
- mode=3 over 257 frames: B at (0,0) reads 0,1,...,255 then 0 again; R at x=200 equals 200.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
//-----------------------------------------------------------------------------
// vga_timing_gen_if
// Video-side bundle of the VGA timing / test-pattern generator.
//   master : the generator (drives sync, enable, coordinates, strobes, RGB;
//            receives the pattern select and solid colour)
//   slave  : the consumer (DAC/HDMI pins, later a frame-buffer reader)
// Signals:
//   mode        [1:0]          pattern select: 0 solid, 1 bars, 2 checker, 3 gradient
//   solid_rgb   [3*COLOR_W-1:0] {R,G,B} colour used by the solid pattern
//   hsync/vsync                sync levels (polarity set on the generator)
//   de                         display enable, high during active video
//   x [X_W-1:0], y [Y_W-1:0]   active pixel coordinates, 0 outside active video
//   line_start/frame_start     one-clk strobes on the first active pixel
//   R, G, B [COLOR_W-1:0]      pixel colour, 0 outside active video
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int COLOR_W = 8,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);
  logic [1:0]           mode;
  logic [3*COLOR_W-1:0] solid_rgb;
  logic                 hsync;
  logic                 vsync;
  logic                 de;
  logic [X_W-1:0]       x;
  logic [Y_W-1:0]       y;
  logic                 line_start;
  logic                 frame_start;
  logic [COLOR_W-1:0]   R;
  logic [COLOR_W-1:0]   G;
  logic [COLOR_W-1:0]   B;

  modport master (
    input  mode, solid_rgb,
    output hsync, vsync, de, x, y, line_start, frame_start, R, G, B
  );

  modport slave (
    output mode, solid_rgb,
    input  hsync, vsync, de, x, y, line_start, frame_start, R, G, B
  );
endinterface

// File: rtl/vga_timing_gen.sv
//-----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing and test-pattern generator. A clock enable derived
// from clk (one pulse every CLK_DIV cycles) advances the horizontal/vertical
// counters; every output is registered on that enable from the decode of the
// current (pre-increment) counter values, so all outputs lag the counters by
// exactly one pixel tick and stay aligned with each other.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   vif  vga_timing_gen_if.master: mode/solid_rgb in; hsync, vsync, de, x, y,
//        line_start, frame_start, R, G, B out
// Region order on both axes: sync, back porch, active, front porch; counter
// value 0 is the first sync pixel/line.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = 8,
  parameter int BAR_W    = 80,
  parameter int CHK_LOG2 = 5
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vif
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_SYNC_END = H_SYNC;
  localparam int unsigned V_SYNC_END = V_SYNC;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned H_STOP  = H_START + H_ACTIVE;  // first column past active
  localparam int unsigned V_STOP  = V_START + V_ACTIVE;  // first line past active

  localparam int HC_W  = $clog2(H_TOTAL);
  localparam int VC_W  = $clog2(V_TOTAL);
  localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BP_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int RGB_W = 3 * COLOR_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [BP_W-1:0]  BAR_LAST = BP_W'(BAR_W - 1);

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  logic [DIV_W-1:0]   div;
  logic               pix_en;
  logic [HC_W-1:0]    hcnt;
  logic [VC_W-1:0]    vcnt;
  logic [COLOR_W-1:0] fcnt;
  logic [BP_W-1:0]    bar_pos;
  logic [2:0]         bar_idx;
  mode_e              shadow_mode;
  logic [RGB_W-1:0]   shadow_rgb;

  // Decode of the current counters
  logic               h_act, v_act, de_d, hs_d, vs_d;
  logic               frame_top, frame_end, chk;
  logic [X_W-1:0]     x_d;
  logic [Y_W-1:0]     y_d;
  logic [2:0]         bar_c;
  logic [RGB_W-1:0]   rgb_d;

  // Registered outputs
  logic               hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [RGB_W-1:0]   rgb_q;

  //--------------------------------------------------------------------------
  // Pixel enable: with CLK_DIV=1 DIV_LAST is 0, div never leaves 0 and
  // pix_en is constantly high.
  //--------------------------------------------------------------------------
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign pix_en = (div == DIV_LAST);

  //--------------------------------------------------------------------------
  // Horizontal / vertical counters
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VC_W'(1);
      end else begin
        hcnt <= hcnt + HC_W'(1);
      end
    end
  end

  assign frame_top = (hcnt == '0) && (vcnt == '0);
  assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

  //--------------------------------------------------------------------------
  // Frame counter (gradient blue) and pattern shadow registers. The shadow
  // loads while the decode sits at (0,0), which is in the sync region, so a
  // new pattern only ever shows from the next frame's first active pixel.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt        <= '0;
      shadow_mode <= MODE_SOLID;
      shadow_rgb  <= '0;
    end else if (pix_en) begin
      if (frame_end) begin
        fcnt <= fcnt + COLOR_W'(1);
      end
      if (frame_top) begin
        shadow_mode <= mode_e'(vif.mode);
        shadow_rgb  <= vif.solid_rgb;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Colour-bar counter: bar_idx/bar_pos always describe the column currently
  // held in hcnt. They are cleared in horizontal blanking, so they read 0 at
  // the first active column, and advance one bar every BAR_W columns with no
  // divider. bar_idx wraps mod 8 by its width.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (pix_en) begin
      if (!h_act) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + BP_W'(1);
      end
    end
  end

  //--------------------------------------------------------------------------
  // Decode of the current counter position
  //--------------------------------------------------------------------------
  assign h_act = (32'(hcnt) >= H_START) && (32'(hcnt) < H_STOP);
  assign v_act = (32'(vcnt) >= V_START) && (32'(vcnt) < V_STOP);
  assign de_d  = h_act && v_act;
  assign hs_d  = (32'(hcnt) < H_SYNC_END) ? HS_POL : ~HS_POL;
  assign vs_d  = (32'(vcnt) < V_SYNC_END) ? VS_POL : ~VS_POL;
  assign x_d   = de_d ? X_W'(32'(hcnt) - H_START) : '0;
  assign y_d   = de_d ? Y_W'(32'(vcnt) - V_START) : '0;
  assign bar_c = 3'd7 - bar_idx;
  // Bit CHK_LOG2 of x xor y, taken on 32-bit copies so CHK_LOG2 may exceed
  // the coordinate widths (the square then covers the whole axis).
  assign chk   = |(((32'(x_d) ^ 32'(y_d)) >> CHK_LOG2) & 32'd1);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rgb_d = '0;
    case (shadow_mode)
      MODE_SOLID:    rgb_d = shadow_rgb;
      MODE_BARS:     rgb_d = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}},
                              {COLOR_W{bar_c[0]}}};
      MODE_CHECKER:  rgb_d = {RGB_W{chk}};
      MODE_GRADIENT: rgb_d = {COLOR_W'(x_d), COLOR_W'(y_d), fcnt};
      default:       rgb_d = '0;
    endcase
    if (!de_d) begin
      rgb_d = '0;
    end
  end

  //--------------------------------------------------------------------------
  // Output stage: loads only on pix_en; the strobes are cleared on every
  // other edge so they last exactly one clk whatever CLK_DIV is.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      hsync_q       <= hs_d;
      vsync_q       <= vs_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      line_start_q  <= de_d && (x_d == '0);
      frame_start_q <= de_d && (x_d == '0) && (y_d == '0);
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.de          = de_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.R           = rgb_q[RGB_W-1 -: COLOR_W];
  assign vif.G           = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vif.B           = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
//-----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen on a small raster (27x15 totals,
// CLK_DIV=3, positive hsync, negative vsync, 4-bit colour). The reference
// model counts clk edges since reset release, converts them to a pixel index
// and derives every output from the raster arithmetic directly.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 20;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 10;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int CLK_DIV  = 3;
  localparam bit HS_POL   = 1'b1;
  localparam bit VS_POL   = 1'b0;
  localparam int COLOR_W  = 4;
  localparam int BAR_W    = 2;
  localparam int CHK_LOG2 = 2;

  localparam int X_W       = $clog2(H_ACTIVE);
  localparam int Y_W       = $clog2(V_ACTIVE);
  localparam int RGB_W     = 3 * COLOR_W;
  localparam int H_TOT     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FRAME     = H_TOT * V_TOT;
  localparam int FRAME_CLK = FRAME * CLK_DIV;
  localparam int CMAX      = (1 << COLOR_W) - 1;
  localparam int N_FRAMES  = 18;

  typedef struct {
    int hs, vs, de, x, y, ls, fs, r, g, b;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [RGB_W-1:0] solid_rgb;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int               k;        // clk edges since reset release
  int               sh_mode;
  logic [RGB_W-1:0] sh_rgb;
  exp_t             e;

  vga_timing_gen_if #(.COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W)) vif ();

  assign vif.mode      = mode;
  assign vif.solid_rgb = solid_rgb;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .HS_POL(HS_POL), .VS_POL(VS_POL),
    .COLOR_W(COLOR_W), .BAR_W(BAR_W), .CHK_LOG2(CHK_LOG2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs for pixel index p counted from reset release.
  function automatic exp_t decode(int p);
    exp_t r;
    int   h, v, f, c;
    bit   act;
    h   = p % H_TOT;
    v   = (p / H_TOT) % V_TOT;
    f   = p / FRAME;
    act = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE) &&
          (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
    r.hs = (h < H_SYNC) ? int'(HS_POL) : int'(!HS_POL);
    r.vs = (v < V_SYNC) ? int'(VS_POL) : int'(!VS_POL);
    r.de = int'(act);
    r.x  = act ? h - (H_SYNC + H_BP) : 0;
    r.y  = act ? v - (V_SYNC + V_BP) : 0;
    r.ls = int'(act && r.x == 0);
    r.fs = int'(act && r.x == 0 && r.y == 0);
    r.r = 0; r.g = 0; r.b = 0;
    if (act) begin
      case (sh_mode)
        0: begin
          r.r = int'(sh_rgb >> (2 * COLOR_W)) & CMAX;
          r.g = int'(sh_rgb >> COLOR_W) & CMAX;
          r.b = int'(sh_rgb) & CMAX;
        end
        1: begin
          c   = 7 - ((r.x / BAR_W) % 8);
          r.r = ((c >> 2) & 1) != 0 ? CMAX : 0;
          r.g = ((c >> 1) & 1) != 0 ? CMAX : 0;
          r.b = (c & 1) != 0 ? CMAX : 0;
        end
        2: begin
          c   = (((r.x >> CHK_LOG2) ^ (r.y >> CHK_LOG2)) & 1) != 0 ? CMAX : 0;
          r.r = c; r.g = c; r.b = c;
        end
        default: begin
          r.r = r.x % (CMAX + 1);
          r.g = r.y % (CMAX + 1);
          r.b = f % (CMAX + 1);
        end
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    k       = 0;
    sh_mode = 0;
    sh_rgb  = '0;
    e = '{hs: int'(!HS_POL), vs: int'(!VS_POL), de: 0, x: 0, y: 0,
          ls: 0, fs: 0, r: 0, g: 0, b: 0};
  endtask

  // Called right after each rising clk edge.
  task automatic model_step();
    int p;
    if (!rst) begin
      k++;
      if (k % CLK_DIV == 0) begin
        p = k / CLK_DIV - 1;
        e = decode(p);
        if (p % FRAME == 0) begin
          sh_mode = int'(mode);
          sh_rgb  = solid_rgb;
        end
      end else begin
        e.ls = 0;
        e.fs = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("hsync",       32'(vif.hsync),       e.hs);
    check("vsync",       32'(vif.vsync),       e.vs);
    check("de",          32'(vif.de),          e.de);
    check("x",           32'(vif.x),           e.x);
    check("y",           32'(vif.y),           e.y);
    check("line_start",  32'(vif.line_start),  e.ls);
    check("frame_start", 32'(vif.frame_start), e.fs);
    check("R",           32'(vif.R),           e.r);
    check("G",           32'(vif.G),           e.g);
    check("B",           32'(vif.B),           e.b);
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (rnd && $urandom_range(0, 299) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        solid_rgb = RGB_W'($urandom);
      end
    end
  endtask

  // Asynchronous reset between clk edges: outputs must reach their reset
  // values before the next edge. Released on a falling edge.
  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1 compare_all();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
    rst = 1'b0;
  endtask

  initial begin
    int first_hs, cnt_hs, cnt_vs, cnt_de, cnt_fs, cnt_ls;
    rst       = 1'b1;
    mode      = 2'd1;
    solid_rgb = RGB_W'(12'h5A3);
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Bars in frame 0, then random pattern changes; reset lands mid-line.
    run_cycles(FRAME_CLK + 37 * CLK_DIV + 1, 1'b1);
    mode = 2'd2;
    pulse_reset(5);
    run_cycles(6 * FRAME_CLK, 1'b1);

    // Gradient from a fresh reset, long enough for the frame counter to wrap.
    mode = 2'd3;
    pulse_reset(5);
    first_hs = -1;
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0; cnt_ls = 0;
    for (int i = 1; i <= N_FRAMES * FRAME_CLK; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (first_hs < 0 && vif.hsync === HS_POL) first_hs = i;
      if (vif.hsync === HS_POL)     cnt_hs++;
      if (vif.vsync === VS_POL)     cnt_vs++;
      if (vif.de === 1'b1)          cnt_de++;
      if (vif.frame_start === 1'b1) cnt_fs++;
      if (vif.line_start === 1'b1)  cnt_ls++;
    end
    check("first_hsync_clk",   first_hs, CLK_DIV);
    check("hsync_active_clks", cnt_hs, N_FRAMES * V_TOT * H_SYNC * CLK_DIV);
    check("vsync_active_clks", cnt_vs, N_FRAMES * V_SYNC * H_TOT * CLK_DIV);
    check("de_clks",           cnt_de, N_FRAMES * V_ACTIVE * H_ACTIVE * CLK_DIV);
    check("frame_starts",      cnt_fs, N_FRAMES);
    check("line_starts",       cnt_ls, N_FRAMES * V_ACTIVE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
